// File: rtl/lsu_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_stage_pkg
// Description : Shared widths, MemOP (funct3) encodings, LSU FSM state codes
//               and the misalignment rule used by the load/store stage.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_stage_pkg;

    localparam int c_REG_WIDTH = 64;  // register / data / address width
    localparam int c_INST_W    = 32;  // instruction width

    // MemOP encodings (funct3 of the load/store instruction)
    localparam logic [2:0] c_MEMOP_B  = 3'b000;
    localparam logic [2:0] c_MEMOP_H  = 3'b001;
    localparam logic [2:0] c_MEMOP_W  = 3'b010;
    localparam logic [2:0] c_MEMOP_D  = 3'b011;
    localparam logic [2:0] c_MEMOP_BU = 3'b100;
    localparam logic [2:0] c_MEMOP_HU = 3'b101;
    localparam logic [2:0] c_MEMOP_WU = 3'b110;

    // LSU state codes
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // An access is misaligned when the byte offset is not a multiple of its size.
    function automatic logic f_misaligned(input logic [2:0] memop, input logic [2:0] offset);
        logic r;
        case (memop)
            c_MEMOP_H, c_MEMOP_HU: r = offset[0];
            c_MEMOP_W, c_MEMOP_WU: r = |offset[1:0];
            c_MEMOP_D:             r = |offset;
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_stage_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_stage_align
// Description : Combinational alignment for the LSU. Builds the store byte
//               mask and shifted store data from the address offset, and
//               extracts / sign- or zero-extends load data from the fetched
//               doubleword.
// Ports       : i_memop    - funct3 of the held op
//               i_offset   - address bits [2:0]
//               i_st_data  - unshifted store data
//               i_rd_data  - raw doubleword from memory
//               o_wmask    - byte-enable mask for the doubleword
//               o_wdata    - store data placed at the byte offset
//               o_ld_data  - extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_stage_align
    import lsu_stage_pkg::*;
#(
    parameter int XLEN = c_REG_WIDTH
) (
    input  logic [2:0]      i_memop,
    input  logic [2:0]      i_offset,
    input  logic [XLEN-1:0] i_st_data,
    input  logic [XLEN-1:0] i_rd_data,
    output logic [7:0]      o_wmask,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_ld_data
);

    logic [5:0]      w_bit_off;
    logic [7:0]      w_base_mask;
    logic [XLEN-1:0] w_shifted;

    assign w_bit_off = {i_offset, 3'b000};
    assign o_wdata   = i_st_data << w_bit_off;
    assign w_shifted = i_rd_data >> w_bit_off;
    assign o_wmask   = w_base_mask << i_offset;

    always_comb begin
        w_base_mask = 8'h00;
        o_ld_data   = '0;
        case (i_memop)
            c_MEMOP_B: begin
                w_base_mask = 8'h01;
                o_ld_data   = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            end
            c_MEMOP_H: begin
                w_base_mask = 8'h03;
                o_ld_data   = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            end
            c_MEMOP_W: begin
                w_base_mask = 8'h0F;
                o_ld_data   = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            end
            c_MEMOP_D: begin
                w_base_mask = 8'hFF;
                o_ld_data   = w_shifted;
            end
            c_MEMOP_BU: begin
                w_base_mask = 8'h01;
                o_ld_data   = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            end
            c_MEMOP_HU: begin
                w_base_mask = 8'h03;
                o_ld_data   = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            end
            c_MEMOP_WU: begin
                w_base_mask = 8'h0F;
                o_ld_data   = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
            end
            default: begin
                w_base_mask = 8'h00;
                o_ld_data   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_stage
// Description : Load/store stage between the EXU pipeline registers and
//               WBRegs. Accepts one op per valid/allow_in handshake, issues
//               at most one request on a single-outstanding memory port and
//               presents the result plus all pass-through fields to WB.
// Ports       : clk, rst (async, active-low)
//               exu_to_lsu_valid / lsu_allow_in   - upstream handshake
//               MemRd, MemWr, MemOP, ALUres, R_rs2 - memory op fields
//               RegSrc .. i_inst / o_*             - pass-through fields
//               MemOut, lsu_misalign, lsu_fault    - result and status
//               lsu_to_wb_valid / wb_allow_in     - downstream handshake
//               mem_req_* / mem_rsp_*             - memory port
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int XLEN   = c_REG_WIDTH,
    parameter int INST_W = c_INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exu_to_lsu_valid,
    output logic              lsu_allow_in,
    input  logic              MemRd,
    input  logic              MemWr,
    input  logic [2:0]        MemOP,
    input  logic [XLEN-1:0]   ALUres,
    input  logic [XLEN-1:0]   R_rs2,
    input  logic [1:0]        RegSrc,
    input  logic              RegWr,
    input  logic              IntrEn,
    input  logic              clint_mtip,
    input  logic [XLEN-1:0]   R_rs1_i,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [INST_W-1:0] i_inst,
    output logic [XLEN-1:0]   o_ALUres,
    output logic [1:0]        o_RegSrc,
    output logic              o_RegWr,
    output logic              o_IntrEn,
    output logic              o_clint_mtip,
    output logic [XLEN-1:0]   o_R_rs1,
    output logic [XLEN-1:0]   o_pc,
    output logic [INST_W-1:0] o_inst,
    output logic [XLEN-1:0]   MemOut,
    output logic              lsu_misalign,
    output logic              lsu_fault,
    output logic              lsu_to_wb_valid,
    input  logic              wb_allow_in,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_rsp_err
);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [1:0]      w_state_accept;
    logic            w_accept;
    logic            w_is_mem_in;
    logic            w_misalign_in;

    logic            r_memrd;
    logic            r_memwr;
    logic [2:0]      r_memop;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_memout;
    logic            r_misalign;
    logic            r_fault;

    logic [7:0]      w_wmask;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_ld_data;

    assign w_accept      = exu_to_lsu_valid && lsu_allow_in;
    assign w_is_mem_in   = MemRd || MemWr;
    assign w_misalign_in = w_is_mem_in && f_misaligned(MemOP, ALUres[2:0]);
    // Misaligned memory ops skip the bus and complete like non-memory ops.
    assign w_state_accept = (w_is_mem_in && !w_misalign_in) ? c_ST_REQ : c_ST_DONE;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_state_nxt = w_state_accept;
            c_ST_REQ:  if (mem_req_ready) w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: if (mem_rsp_valid) w_state_nxt = c_ST_DONE;
            c_ST_DONE: begin
                if (w_accept)         w_state_nxt = w_state_accept;
                else if (wb_allow_in) w_state_nxt = c_ST_IDLE;
            end
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        lsu_allow_in    = 1'b0;
        mem_req_valid   = 1'b0;
        lsu_to_wb_valid = 1'b0;
        case (r_state)
            c_ST_IDLE: lsu_allow_in = 1'b1;
            c_ST_REQ:  mem_req_valid = 1'b1;
            c_ST_DONE: begin
                lsu_to_wb_valid = 1'b1;
                lsu_allow_in    = wb_allow_in;
            end
            default: ;
        endcase
    end

    // ---------------- op capture and result ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_ALUres     <= '0;
            o_RegSrc     <= '0;
            o_RegWr      <= 1'b0;
            o_IntrEn     <= 1'b0;
            o_clint_mtip <= 1'b0;
            o_R_rs1      <= '0;
            o_pc         <= '0;
            o_inst       <= '0;
            r_memrd      <= 1'b0;
            r_memwr      <= 1'b0;
            r_memop      <= '0;
            r_rs2        <= '0;
            r_memout     <= '0;
            r_misalign   <= 1'b0;
            r_fault      <= 1'b0;
        end else if (w_accept) begin
            o_ALUres     <= ALUres;
            o_RegSrc     <= RegSrc;
            o_RegWr      <= RegWr;
            o_IntrEn     <= IntrEn;
            o_clint_mtip <= clint_mtip;
            o_R_rs1      <= R_rs1_i;
            o_pc         <= i_pc;
            o_inst       <= i_inst;
            r_memrd      <= MemRd;
            r_memwr      <= MemWr;
            r_memop      <= MemOP;
            r_rs2        <= R_rs2;
            r_memout     <= '0;
            r_misalign   <= w_misalign_in;
            r_fault      <= 1'b0;
        end else if (r_state == c_ST_WAIT && mem_rsp_valid) begin
            // Responses arriving in any other state are stale and dropped.
            r_fault  <= mem_rsp_err;
            r_memout <= (r_memrd && !mem_rsp_err) ? w_ld_data : '0;
        end
    end

    lsu_stage_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_memop   (r_memop),
        .i_offset  (o_ALUres[2:0]),
        .i_st_data (r_rs2),
        .i_rd_data (mem_rdata),
        .o_wmask   (w_wmask),
        .o_wdata   (w_wdata),
        .o_ld_data (w_ld_data)
    );

    assign mem_addr     = {o_ALUres[XLEN-1:3], 3'b000};
    assign mem_wen      = r_memwr;
    assign mem_wdata    = w_wdata;
    // Mask is only meaningful for memory ops; keeps the port at 0 after reset.
    assign mem_wmask    = (r_memrd || r_memwr) ? w_wmask : 8'h00;
    assign MemOut       = r_memout;
    assign lsu_misalign = r_misalign;
    assign lsu_fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_lsu_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_stage
// Description : Self-checking bench for lsu_stage. Directed ops are applied
//               one at a time; a behavioural model derives the expected
//               request and write-back fields, a compare process checks them
//               on every meaningful cycle, and literal values pin key cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_stage;

    localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010, OP_D = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100, OP_HU = 3'b101, OP_WU = 3'b110;

    logic        clk, rst;
    logic        exu_to_lsu_valid, lsu_allow_in;
    logic        MemRd, MemWr;
    logic [2:0]  MemOP;
    logic [63:0] ALUres, R_rs2, R_rs1_i, i_pc;
    logic [1:0]  RegSrc;
    logic        RegWr, IntrEn, clint_mtip;
    logic [31:0] i_inst;
    logic [63:0] o_ALUres, o_R_rs1, o_pc;
    logic [1:0]  o_RegSrc;
    logic        o_RegWr, o_IntrEn, o_clint_mtip;
    logic [31:0] o_inst;
    logic [63:0] MemOut;
    logic        lsu_misalign, lsu_fault, lsu_to_wb_valid, wb_allow_in;
    logic        mem_req_valid, mem_req_ready, mem_wen;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid, mem_rsp_err;

    int vectors = 0;
    int misses  = 0;
    int op_num  = 0;
    logic cmp_en = 1'b0;

    // expected values from the model
    logic [63:0] exp_memout, exp_alures, exp_pc, exp_rs1;
    logic [31:0] exp_inst;
    logic        exp_mis, exp_fault, exp_regwr, exp_req_ok, exp_wen;
    logic [63:0] exp_addr, exp_wdata;
    logic [7:0]  exp_wmask;

    // observed values captured by the driver for literal checks
    logic [63:0] got_memout, got_alures, got_addr, got_wdata;
    logic [7:0]  got_wmask;
    logic        got_mis, got_fault;

    lsu_stage dut (
        .clk(clk), .rst(rst),
        .exu_to_lsu_valid(exu_to_lsu_valid), .lsu_allow_in(lsu_allow_in),
        .MemRd(MemRd), .MemWr(MemWr), .MemOP(MemOP), .ALUres(ALUres), .R_rs2(R_rs2),
        .RegSrc(RegSrc), .RegWr(RegWr), .IntrEn(IntrEn), .clint_mtip(clint_mtip),
        .R_rs1_i(R_rs1_i), .i_pc(i_pc), .i_inst(i_inst),
        .o_ALUres(o_ALUres), .o_RegSrc(o_RegSrc), .o_RegWr(o_RegWr), .o_IntrEn(o_IntrEn),
        .o_clint_mtip(o_clint_mtip), .o_R_rs1(o_R_rs1), .o_pc(o_pc), .o_inst(o_inst),
        .MemOut(MemOut), .lsu_misalign(lsu_misalign), .lsu_fault(lsu_fault),
        .lsu_to_wb_valid(lsu_to_wb_valid), .wb_allow_in(wb_allow_in),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_rsp_err(mem_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [2:0] op);
        return 1 << op[1:0];
    endfunction

    function automatic logic m_mis(input logic [2:0] op, input logic [2:0] off);
        return (int'(off) % m_size(op)) != 0;
    endfunction

    function automatic logic [7:0] m_mask(input logic [2:0] op, input logic [2:0] off);
        logic [15:0] m;
        m = ((16'd1 << m_size(op)) - 16'd1) << off;
        return m[7:0];
    endfunction

    // Assemble the little-endian value from the addressed bytes, then
    // sign-extend by subtracting 2^bits when the top bit is set.
    function automatic logic [63:0] m_load(input logic [2:0] op, input logic [2:0] off,
                                           input logic [63:0] rdata);
        logic [7:0]  bytes [8];
        logic [63:0] val;
        int          size;
        for (int i = 0; i < 8; i++) bytes[i] = rdata[8*i +: 8];
        size = m_size(op);
        val  = 64'd0;
        for (int i = size - 1; i >= 0; i--) val = (val << 8) | {56'd0, bytes[(int'(off) + i) % 8]};
        if (!op[2] && size < 8 && val[8*size-1]) val = val - (64'd1 << (8*size));
        return val;
    endfunction

    task automatic set_exp(input logic rd, input logic wr, input logic [2:0] op,
                           input logic [63:0] addr, input logic [63:0] rs2,
                           input logic [63:0] rdata, input logic err);
        logic mem;
        mem        = rd || wr;
        op_num++;
        exp_mis    = mem && m_mis(op, addr[2:0]);
        exp_req_ok = mem && !exp_mis;
        exp_fault  = exp_req_ok && err;
        exp_memout = (rd && exp_req_ok && !err) ? m_load(op, addr[2:0], rdata) : 64'd0;
        exp_alures = addr;
        exp_pc     = 64'h8000_0000 + 64'(op_num * 4);
        exp_inst   = 32'h0000_0013 + 32'(op_num);
        exp_rs1    = 64'hA5A5_0000_0000_0000 + 64'(op_num);
        exp_regwr  = op_num[0];
        exp_addr   = {addr[63:3], 3'b000};
        exp_wdata  = rs2 << (8 * int'(addr[2:0]));
        exp_wmask  = m_mask(op, addr[2:0]);
        exp_wen    = wr;
        MemRd = rd; MemWr = wr; MemOP = op; ALUres = addr; R_rs2 = rs2;
        i_pc = exp_pc; i_inst = exp_inst; R_rs1_i = exp_rs1; RegWr = exp_regwr;
    endtask

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (cmp_en && rst) begin
            if (lsu_to_wb_valid) begin
                chk("wb_memout", MemOut, exp_memout);
                chk("wb_misalign", {63'd0, lsu_misalign}, {63'd0, exp_mis});
                chk("wb_fault", {63'd0, lsu_fault}, {63'd0, exp_fault});
                chk("wb_alures", o_ALUres, exp_alures);
                chk("wb_pc", o_pc, exp_pc);
                chk("wb_inst", {32'd0, o_inst}, {32'd0, exp_inst});
                chk("wb_rs1", o_R_rs1, exp_rs1);
                chk("wb_regwr", {63'd0, o_RegWr}, {63'd0, exp_regwr});
            end
            if (mem_req_valid) begin
                chk("req_legal", {63'd0, exp_req_ok}, 64'd1);
                chk("req_addr", mem_addr, exp_addr);
                chk("req_wdata", mem_wdata, exp_wdata);
                chk("req_wmask", {56'd0, mem_wmask}, {56'd0, exp_wmask});
                chk("req_wen", {63'd0, mem_wen}, {63'd0, exp_wen});
            end
        end
    end

    // ---------------- directed op driver ----------------
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] op,
                          input logic [63:0] addr, input logic [63:0] rs2,
                          input logic [63:0] rdata, input logic err, input int rdy_dly);
        int n;
        set_exp(rd, wr, op, addr, rs2, rdata, err);
        exu_to_lsu_valid = 1'b1;
        @(negedge clk);
        exu_to_lsu_valid = 1'b0;
        if (exp_req_ok) begin
            n = 0;
            while (!mem_req_valid && n < 20) begin @(negedge clk); n++; end
            if (!mem_req_valid) chk("req_timeout", 64'd0, 64'd1);
            got_addr = mem_addr; got_wdata = mem_wdata; got_wmask = mem_wmask;
            repeat (rdy_dly) begin
                @(negedge clk);
                chk("req_hold", {63'd0, mem_req_valid}, 64'd1);
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            chk("req_drop", {63'd0, mem_req_valid}, 64'd0);
            mem_rsp_valid = 1'b1; mem_rdata = rdata; mem_rsp_err = err;
            @(negedge clk);
            mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        end else begin
            chk("direct_latency", {63'd0, lsu_to_wb_valid}, 64'd1);
        end
        n = 0;
        while (!lsu_to_wb_valid && n < 20) begin @(negedge clk); n++; end
        if (!lsu_to_wb_valid) chk("wb_timeout", 64'd0, 64'd1);
        got_memout = MemOut; got_alures = o_ALUres; got_mis = lsu_misalign; got_fault = lsu_fault;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        exu_to_lsu_valid = 1'b0; MemRd = 1'b0; MemWr = 1'b0; MemOP = 3'd0;
        ALUres = '0; R_rs2 = '0; R_rs1_i = '0; i_pc = '0; i_inst = '0;
        RegSrc = 2'd1; RegWr = 1'b0; IntrEn = 1'b0; clint_mtip = 1'b0;
        wb_allow_in = 1'b1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rdata = '0; mem_rsp_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_allow_in", {63'd0, lsu_allow_in}, 64'd1);
        chk("rst_wb_valid", {63'd0, lsu_to_wb_valid}, 64'd0);
        chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_memout", MemOut, 64'd0);
        chk("rst_alures", o_ALUres, 64'd0);
        chk("rst_wmask", {56'd0, mem_wmask}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;

        // non-memory op
        run_op(1'b0, 1'b0, OP_D, 64'hDEAD_BEEF_0000_1234, 64'h55, 64'h0, 1'b0, 0);
        chk("nonmem_memout", got_memout, 64'd0);
        chk("nonmem_alures", got_alures, 64'hDEAD_BEEF_0000_1234);

        // byte loads at offset 3
        run_op(1'b1, 1'b0, OP_B, 64'h1000_0003, 64'h0, 64'h0000_0080_0000_0000, 1'b0, 0);
        chk("lb_zero", got_memout, 64'd0);
        run_op(1'b1, 1'b0, OP_B, 64'h1000_0003, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 0);
        chk("lb_neg", got_memout, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(1'b1, 1'b0, OP_BU, 64'h1000_0003, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 1);
        chk("lbu", got_memout, 64'h80);

        // halfword store at offset 6
        run_op(1'b0, 1'b1, OP_H, 64'h1000_0006, 64'h1234, 64'h0, 1'b0, 0);
        chk("sh_addr", got_addr, 64'h1000_0000);
        chk("sh_wmask", {56'd0, got_wmask}, 64'hC0);
        chk("sh_wdata", got_wdata, 64'h1234_0000_0000_0000);

        // misaligned word load: no bus access
        run_op(1'b1, 1'b0, OP_W, 64'h1000_0002, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        chk("lw_mis_flag", {63'd0, got_mis}, 64'd1);
        chk("lw_mis_memout", got_memout, 64'd0);

        // load with ready held low 3 cycles and bus error
        run_op(1'b1, 1'b0, OP_D, 64'h2000_0008, 64'h0, 64'h1122_3344_5566_7788, 1'b1, 3);
        chk("err_fault", {63'd0, got_fault}, 64'd1);
        chk("err_memout", got_memout, 64'd0);

        // assorted loads/stores checked through the model
        run_op(1'b1, 1'b0, OP_H,  64'h3000_0006, 64'h0, 64'h8877_6655_F4F3_F2F1, 1'b0, 0);
        run_op(1'b1, 1'b0, OP_HU, 64'h3000_0002, 64'h0, 64'h8877_6655_F4F3_F2F1, 1'b0, 2);
        run_op(1'b1, 1'b0, OP_W,  64'h3000_0000, 64'h0, 64'h8877_6655_F4F3_F2F1, 1'b0, 0);
        run_op(1'b1, 1'b0, OP_WU, 64'h3000_0004, 64'h0, 64'h8877_6655_F4F3_F2F1, 1'b0, 1);
        run_op(1'b1, 1'b0, OP_D,  64'h3000_0010, 64'h0, 64'h8877_6655_F4F3_F2F1, 1'b0, 0);
        chk("ld_full", got_memout, 64'h8877_6655_F4F3_F2F1);
        run_op(1'b0, 1'b1, OP_W, 64'h4000_0004, 64'hCAFE_BABE, 64'h0, 1'b0, 0);
        run_op(1'b0, 1'b1, OP_B, 64'h4000_0005, 64'hAB, 64'h0, 1'b0, 1);
        run_op(1'b0, 1'b1, OP_D, 64'h4000_0008, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b1, 0);
        chk("sd_err_fault", {63'd0, got_fault}, 64'd1);
        run_op(1'b0, 1'b1, OP_D, 64'h4000_000C, 64'h1, 64'h0, 1'b0, 0);
        chk("sd_mis_flag", {63'd0, got_mis}, 64'd1);

        // backpressure: WB not ready holds the result for 4 cycles
        wb_allow_in = 1'b0;
        set_exp(1'b0, 1'b0, OP_B, 64'h5555_AAAA_0000_0001, 64'h0, 64'h0, 1'b0);
        exu_to_lsu_valid = 1'b1;
        @(negedge clk);
        exu_to_lsu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", {63'd0, lsu_to_wb_valid}, 64'd1);
            chk("bp_allow_in", {63'd0, lsu_allow_in}, 64'd0);
            chk("bp_alures", o_ALUres, 64'h5555_AAAA_0000_0001);
            @(negedge clk);
        end
        wb_allow_in = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {63'd0, lsu_to_wb_valid}, 64'd0);
        chk("bp_release_allow", {63'd0, lsu_allow_in}, 64'd1);

        // reset while waiting for a response; the later response is ignored
        set_exp(1'b1, 1'b0, OP_D, 64'h6000_0010, 64'h0, 64'h0, 1'b0);
        exu_to_lsu_valid = 1'b1;
        @(negedge clk);
        exu_to_lsu_valid = 1'b0;
        chk("rw_req", {63'd0, mem_req_valid}, 64'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rw_wait_allow", {63'd0, lsu_allow_in}, 64'd0);
        #2 rst = 1'b0;
        #1;
        chk("rw_allow_in", {63'd0, lsu_allow_in}, 64'd1);
        chk("rw_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rw_alures", o_ALUres, 64'd0);
        chk("rw_addr", mem_addr, 64'd0);
        chk("rw_pc", o_pc, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_rsp_valid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("stale_valid", {63'd0, lsu_to_wb_valid}, 64'd0);
        chk("stale_memout", MemOut, 64'd0);
        @(negedge clk);
        chk("stale_allow", {63'd0, lsu_allow_in}, 64'd1);
        chk("stale_valid2", {63'd0, lsu_to_wb_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

    // absolute bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
